// File: rtl/mux_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux path.
// One owner at a time; a grant is held until done, withdrawal, or HOLD_MAX cycles.
module mux_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  // state | meaning
  // IDLE  | no owner; pick the next requester starting at ptr
  // GRANT | owner sel holds the path; cnt counts held cycles

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sel_d;
  logic [3:0] grant_d;
  logic       busy_d;
  logic       timeout_d;

  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;
  logic       at_limit;
  logic       release_now;

  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign at_limit    = (cnt_q == CNT_LAST);
  assign release_now = done || !req[sel] || at_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      sel     <= 2'd0;
      grant   <= 4'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      grant   <= grant_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel;
    grant_d   = 4'd0;
    busy_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = winner;
          grant_d = 4'b0001 << winner;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          ptr_d   = winner + 2'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          // a normal release (done or withdrawal) masks the timeout flag
          timeout_d = at_limit && !done && req[sel];
        end else begin
          grant_d = grant;
          busy_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: a vector table plus hand sequences for
// hold-limit timeout, done at the limit, and reset mid-grant.
module tb_mux_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  mux_arbiter #(.HOLD_MAX(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       t;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic [3:0] g, input logic [1:0] s,
                     input logic b, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.g = g; v.s = s; v.b = b; v.t = t;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic d);
    reset = r;
    req   = rq;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] g,
                       input logic [1:0] s, input logic b, input logic t);
    n_cmp++;
    if (grant !== g || sel !== s || busy !== b || timeout !== t) begin
      n_err++;
      $display("FAIL %s: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
               name, grant, sel, busy, timeout, g, s, b, t);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'd0;
    done  = 1'b0;

    //   rst req      done grant    sel busy to
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 1, 4'b0000, 2, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 2, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 2, 0, 0);
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 3, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b1000, 0, 4'b0000, 1, 0, 0);
    add(0, 4'b1000, 0, 4'b1000, 3, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 3, 0, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0011, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].done);
      check($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].b, tbl[i].t);
    end

    // hold limit: 8 grant cycles, one timeout/idle cycle, then re-grant
    step(1, 4'b0000, 0);
    check("to_reset", 4'b0000, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 4'b0001, 0);
      check($sformatf("to_hold%0d", k), 4'b0001, 0, 1, 0);
    end
    step(0, 4'b0001, 0);
    check("to_pulse", 4'b0000, 0, 0, 1);
    step(0, 4'b0001, 0);
    check("to_regrant", 4'b0001, 0, 1, 0);
    step(0, 4'b0000, 0);
    check("to_release", 4'b0000, 0, 0, 0);

    // done coincides with the last hold cycle
    step(1, 4'b0000, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 4'b0001, 0);
      check($sformatf("dl_hold%0d", k), 4'b0001, 0, 1, 0);
    end
    step(0, 4'b0001, 1);
    check("dl_release", 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 0);
    check("dl_after", 4'b0000, 0, 0, 0);

    // withdrawal coincides with the last hold cycle
    step(1, 4'b0000, 0);
    for (int k = 0; k < 8; k++) step(0, 4'b0010, 0);
    check("wl_hold7", 4'b0010, 1, 1, 0);
    step(0, 4'b0000, 0);
    check("wl_release", 4'b0000, 1, 0, 0);

    // reset mid-grant wins, then pointer restarts at 0
    step(1, 4'b0000, 0);
    step(0, 4'b1111, 0);
    step(0, 4'b1111, 1);
    step(0, 4'b1111, 0);
    check("rm_grant1", 4'b0010, 1, 1, 0);
    step(1, 4'b1111, 1);
    check("rm_reset", 4'b0000, 0, 0, 0);
    step(0, 4'b1111, 0);
    check("rm_first", 4'b0001, 0, 1, 0);

    // reset in the same cycle the hold limit would fire
    step(1, 4'b0000, 0);
    for (int k = 0; k < 8; k++) step(0, 4'b0100, 0);
    step(1, 4'b0100, 0);
    check("rt_reset", 4'b0000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_MAX, default 8, which is the maximum number of cycles one grant is held (legal range 2..255).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: reset SHALL be synchronous and active-high.
REQ-004 Port req, input, 4 bits: req[n] is requester n asking for the shared 4:1 mux path.
REQ-005 Port done, input, 1 bit: the current owner releases the path; done SHALL be ignored while busy=0.
REQ-006 Port sel, output, 2 bits: the mux select, equal to the index of the current or last owner.
REQ-007 Port grant, output, 4 bits: one-hot owner indication, or all zeros when no owner.
REQ-008 Port busy, output, 1 bit: 1 while a grant is active.
REQ-009 Port timeout, output, 1 bit: a one-cycle pulse when a grant is revoked by the HOLD_MAX limit.

Function
REQ-010 The block SHALL implement two states, IDLE and GRANT, all outputs registered.
REQ-011 The block SHALL hold a 2-bit priority pointer ptr; the search order SHALL be ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-012 In IDLE with req!=0 at an edge, the block SHALL enter GRANT and set these values after that edge:
- winner = first set req bit in search order
- sel = winner, grant = 1<<winner, busy = 1
- hold counter cnt = 0
- ptr = winner+1 mod 4
REQ-013 Latency from req first sampled high in IDLE to grant asserted SHALL be exactly 1 cycle.
REQ-014 In IDLE with req==0, the block SHALL keep state, grant=0, busy=0, and keep sel at its last value.
REQ-015 In GRANT, the block SHALL release the grant at an edge if any of the following is true:
- done=1
- req[sel]=0 (requester withdrew)
- cnt==HOLD_MAX-1
REQ-016 On release, the block SHALL go to IDLE with grant=0 and busy=0 after that edge.
REQ-017 At least one IDLE cycle SHALL separate consecutive grants, with no back-to-back handoff.
REQ-018 In GRANT without release, cnt SHALL increment by 1 per cycle, 8 bits wide, and SHALL never wrap because release occurs at HOLD_MAX-1.
REQ-019 The maximum grant duration SHALL be exactly HOLD_MAX cycles of grant high.
REQ-020 timeout SHALL be 1 for the single cycle after a release caused only by cnt==HOLD_MAX-1.
REQ-021 If done=1 or req[sel]=0 coincides with cnt==HOLD_MAX-1, timeout SHALL stay 0 (a normal release takes precedence).
REQ-022 Changes to req bits other than the owner's SHALL NOT affect an active grant.
REQ-023 grant SHALL never have more than one bit set.
REQ-024 grant!=0 SHALL hold if and only if busy=1.
REQ-025 When busy=1, grant[sel] SHALL be 1.
REQ-026 Fairness: with all four req held high continuously, grants SHALL rotate 0,1,2,3,0,...

Reset
REQ-027 With reset=1 at an edge, the block SHALL set after that edge: state=IDLE, grant=0, sel=0, busy=0, timeout=0, ptr=0, cnt=0.
REQ-028 Reset SHALL take precedence over every other input, including mid-GRANT and in the same cycle as done or timeout.
REQ-029 In the first cycle after reset deasserts, requests SHALL be evaluated with ptr=0.

Verification
REQ-030 The bench SHALL cover: reset, then req=4'b0100 held -> one cycle later grant=4'b0100, sel=2, busy=1; done pulse -> next cycle grant=0, busy=0, timeout=0.
REQ-031 The bench SHALL cover: all req=4'b1111, done pulsed 2 cycles into each grant -> grant order 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
REQ-032 The bench SHALL cover: HOLD_MAX=8, req=4'b0001 held, done=0 -> grant high exactly 8 cycles, then timeout=1 for one cycle with grant=0; re-grant to 0 occurs after one IDLE cycle.
REQ-033 The bench SHALL cover: done=1 in the same cycle as cnt=HOLD_MAX-1 -> release with timeout=0.
REQ-034 The bench SHALL cover: owner 1 granted, req[1] dropped while req[3]=1 -> grant=0 next cycle, then grant=4'b1000 one cycle later.
REQ-035 The bench SHALL cover: reset=1 asserted mid-grant with req=4'b1111 -> next cycle all outputs 0; after reset deasserts, first grant=4'b0001.
